smc_3_1_law: RTL and testbench

Sliding-mode control-law stage for the SMC_3_1 loop. Runs once per controller period on a `start` strobe:
- Latches measured position/velocity and the nominal-model trajectory from `smc_3_1_nominal`.
- Computes the sliding surface, applies the switching function, scales by the gain, and clamps.
- Drives the `u` input and `done` strobe of `smc_3_1_nominal`.

All arithmetic is sfix32_En16 on one shared datapath sequenced by a fixed-latency FSM.

---
 rtl/smc_3_1_law_if.sv | 32 +++
 rtl/smc_3_1_law.sv | 205 ++++++++++++++++++++
 tb/tb_smc_3_1_law.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/smc_3_1_law_if.sv
// smc_3_1_law_if: control/data bundle between the SMC_3_1 loop sequencer and
// the sliding-mode control-law stage.
//   stop_rst  synchronous clear, active high
//   start     one-cycle request strobe
//   theta, dtheta, thetan, dthetan  measured and nominal state, sfix32_En16
//   u         control output, sfix32_En16
//   done      one-cycle completion strobe
//   busy      stage is mid-computation
//   ov        sticky arithmetic-saturation flag
// master: requester side; slave: control-law stage.
interface smc_3_1_law_if;
  logic        stop_rst;
  logic        start;
  logic [31:0] theta;
  logic [31:0] dtheta;
  logic [31:0] thetan;
  logic [31:0] dthetan;
  logic [31:0] u;
  logic        done;
  logic        busy;
  logic        ov;

  modport master (
    output stop_rst, start, theta, dtheta, thetan, dthetan,
    input  u, done, busy, ov
  );

  modport slave (
    input  stop_rst, start, theta, dtheta, thetan, dthetan,
    output u, done, busy, ov
  );
endinterface

// File: rtl/smc_3_1_law.sv
// smc_3_1_law: sliding-mode control-law stage, one shared sfix32_En16
// datapath sequenced by a fixed 6-cycle FSM (IDLE ERR MUL1 SURF SAT MUL2 OUT).
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    smc_3_1_law_if.slave (stop_rst, start, theta/dtheta/thetan/dthetan
//          in; u, done, busy, ov out, all registered)
// Build option: define SMC_BOUNDARY_LAYER_EN for a boundary-layer switching
// function clamp(s <<< PHI_SHIFT, +-1.0); otherwise sign(s) is used.
module smc_3_1_law #(
  parameter logic signed [31:0] LAMBDA    = 32'sh0005_0000,
  parameter logic signed [31:0] K         = 32'sh0002_0000,
  parameter int unsigned        PHI_SHIFT = 4,
  parameter logic signed [31:0] U_MAX     = 32'sh0010_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  smc_3_1_law_if.slave   bus
);

  localparam int unsigned W  = 32;
  localparam int unsigned SW = W + 16;
  localparam logic signed [W-1:0]  ONE    = 32'sh0001_0000;
  localparam logic signed [W-1:0]  MAXP   = 32'sh7FFF_FFFF;
  localparam logic signed [W-1:0]  MINN   = 32'sh8000_0000;
  localparam logic signed [SW-1:0] ONE_SW = 48'sh0000_0001_0000;

  // Elaboration-time range check on the boundary-layer shift
  if (PHI_SHIFT > 15) begin : g_phi_range
    $error("PHI_SHIFT must be in 0..15");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_MUL1, S_SURF, S_SAT, S_MUL2, S_OUT
  } state_t;

  state_t state_q, state_d;
  logic signed [W-1:0] th_q, dth_q, thn_q, dthn_q;
  logic signed [W-1:0] th_d, dth_d, thn_d, dthn_d;
  logic signed [W-1:0] acc_q, acc_d, de_q, de_d, u_q, u_d;
  logic                done_q, done_d, busy_q, busy_d, ov_q, ov_d;
  logic [W:0]          res_a, res_b;
  logic signed [W-1:0] nv;

  // Saturating add/sub; returns {overflow, result}
  function automatic logic [W:0] add_sat(input logic signed [W-1:0] a,
                                         input logic signed [W-1:0] b,
                                         input logic sub);
    logic [W:0] r;
    r = sub ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
    if (r[W] != r[W-1]) return {1'b1, (r[W] ? MINN : MAXP)};
    return {1'b0, r[W-1:0]};
  endfunction

  // Q16 multiply, floor truncation, saturate when bits [63:47] disagree
  function automatic logic [W:0] mul_sat(input logic signed [W-1:0] a,
                                         input logic signed [W-1:0] b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    if (!((&p[63:47]) || !(|p[63:47]))) return {1'b1, (p[63] ? MINN : MAXP)};
    return {1'b0, p[47:16]};
  endfunction

  // Negation with the single overflow case saturated
  function automatic logic [W:0] neg_sat(input logic signed [W-1:0] a);
    if (a == MINN) return {1'b1, MAXP};
    return {1'b0, -a};
  endfunction

  // Switching function
  function automatic logic signed [W-1:0] sat_fn(input logic signed [W-1:0] s);
`ifdef SMC_BOUNDARY_LAYER_EN
    logic signed [SW-1:0] sh;
    sh = SW'(s) <<< PHI_SHIFT;
    if (sh > ONE_SW) return ONE;
    if (sh < -ONE_SW) return -ONE;
    return W'(sh);
`else
    if (s > 32'sd0) return ONE;
    if (s < 32'sd0) return -ONE;
    return 32'sd0;
`endif
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      th_q    <= '0;
      dth_q   <= '0;
      thn_q   <= '0;
      dthn_q  <= '0;
      acc_q   <= '0;
      de_q    <= '0;
      u_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      th_q    <= th_d;
      dth_q   <= dth_d;
      thn_q   <= thn_d;
      dthn_q  <= dthn_d;
      acc_q   <= acc_d;
      de_q    <= de_d;
      u_q     <= u_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ov_q    <= ov_d;
    end
  end

  // Next-state and datapath sequencing; acc carries e -> p -> s -> sw -> q
  always_comb begin
    state_d = state_q;
    th_d    = th_q;
    dth_d   = dth_q;
    thn_d   = thn_q;
    dthn_d  = dthn_q;
    acc_d   = acc_q;
    de_d    = de_q;
    u_d     = u_q;
    done_d  = 1'b0;
    ov_d    = ov_q;
    res_a   = '0;
    res_b   = '0;
    nv      = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          th_d    = bus.theta;
          dth_d   = bus.dtheta;
          thn_d   = bus.thetan;
          dthn_d  = bus.dthetan;
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        res_a   = add_sat(th_q, thn_q, 1'b1);
        res_b   = add_sat(dth_q, dthn_q, 1'b1);
        acc_d   = res_a[W-1:0];
        de_d    = res_b[W-1:0];
        ov_d    = ov_q | res_a[W] | res_b[W];
        state_d = S_MUL1;
      end
      S_MUL1: begin
        res_a   = mul_sat(LAMBDA, acc_q);
        acc_d   = res_a[W-1:0];
        ov_d    = ov_q | res_a[W];
        state_d = S_SURF;
      end
      S_SURF: begin
        res_a   = add_sat(de_q, acc_q, 1'b0);
        acc_d   = res_a[W-1:0];
        ov_d    = ov_q | res_a[W];
        state_d = S_SAT;
      end
      S_SAT: begin
        acc_d   = sat_fn(acc_q);
        state_d = S_MUL2;
      end
      S_MUL2: begin
        res_a   = mul_sat(K, acc_q);
        acc_d   = res_a[W-1:0];
        ov_d    = ov_q | res_a[W];
        state_d = S_OUT;
      end
      S_OUT: begin
        // Output limit is a control clamp, not an arithmetic overflow
        res_a   = neg_sat(acc_q);
        nv      = res_a[W-1:0];
        ov_d    = ov_q | res_a[W];
        if (nv > U_MAX)       u_d = U_MAX;
        else if (nv < -U_MAX) u_d = -U_MAX;
        else                  u_d = nv;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Synchronous clear drops any in-flight computation
    if (bus.stop_rst) begin
      state_d = S_IDLE;
      th_d    = '0;
      dth_d   = '0;
      thn_d   = '0;
      dthn_d  = '0;
      acc_d   = '0;
      de_d    = '0;
      u_d     = '0;
      done_d  = 1'b0;
      ov_d    = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign bus.u    = u_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.ov   = ov_q;

endmodule

// File: tb/tb_smc_3_1_law.sv
// tb_smc_3_1_law: directed self-checking bench for smc_3_1_law. Instance a
// uses default parameters; instance b uses K = 32.0 to exercise the U_MAX clamp.
module tb_smc_3_1_law;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  smc_3_1_law_if bus_a ();
  smc_3_1_law_if bus_b ();

  smc_3_1_law u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  smc_3_1_law #(.K(32'sh0020_0000)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request on instance a; lat = cycles from start edge to done
  task automatic run_a(input logic [31:0] th, input logic [31:0] dth,
                       input logic [31:0] thn, input logic [31:0] dthn,
                       output logic [31:0] u_o, output logic ov_o,
                       output int lat);
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.theta = th; bus_a.dtheta = dth; bus_a.thetan = thn; bus_a.dthetan = dthn;
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_a.theta = 32'hDEAD_BEEF; bus_a.dtheta = 32'h1234_5678;
    bus_a.thetan = 32'h8765_4321; bus_a.dthetan = 32'hCAFE_F00D;
    lat = -1; u_o = '0; ov_o = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus_a.done === 1'b1 && lat < 0) begin
        lat = k; u_o = bus_a.u; ov_o = bus_a.ov;
      end
    end
    if (lat < 0) begin u_o = bus_a.u; ov_o = bus_a.ov; end
  endtask

  task automatic run_b(input logic [31:0] th, output logic [31:0] u_o,
                       output logic ov_o, output int lat);
    @(negedge clk);
    bus_b.start = 1'b1; bus_b.theta = th;
    @(negedge clk);
    bus_b.start = 1'b0; bus_b.theta = 32'h0BAD_0BAD;
    lat = -1; u_o = '0; ov_o = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus_b.done === 1'b1 && lat < 0) begin
        lat = k; u_o = bus_b.u; ov_o = bus_b.ov;
      end
    end
    if (lat < 0) begin u_o = bus_b.u; ov_o = bus_b.ov; end
  endtask

  task automatic test_reset();
    checks++; if (bus_a.u !== 32'h0) begin failures++; $display("FAIL reset_u: got %h expected 00000000", bus_a.u); end
    checks++; if (bus_a.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus_a.done); end
    checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus_a.busy); end
    checks++; if (bus_a.ov !== 1'b0) begin failures++; $display("FAIL reset_ov: got %b expected 0", bus_a.ov); end
  endtask

  task automatic test_zero_error();
    logic [31:0] u; logic ov; int lat;
    run_a(32'h0003_0000, 32'h0, 32'h0003_0000, 32'h0, u, ov, lat);
    checks++; if (lat !== 6) begin failures++; $display("FAIL zero_latency: got %0d expected 6", lat); end
    checks++; if (u !== 32'h0) begin failures++; $display("FAIL zero_u: got %h expected 00000000", u); end
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL zero_ov: got %b expected 0", ov); end
  endtask

  task automatic test_boundary_layer();
    logic [31:0] u; logic ov; int lat; logic [31:0] exp_u;
`ifdef SMC_BOUNDARY_LAYER_EN
    exp_u = 32'hFFFE_66A0;
`else
    exp_u = 32'hFFFE_0000;
`endif
    run_a(32'h0000_028F, 32'h0, 32'h0, 32'h0, u, ov, lat);
    checks++; if (u !== exp_u) begin failures++; $display("FAIL boundary_u: got %h expected %h", u, exp_u); end
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL boundary_ov: got %b expected 0", ov); end
  endtask

  task automatic test_large_error();
    logic [31:0] u; logic ov; int lat;
    run_a(32'h0001_0000, 32'h0, 32'h0, 32'h0, u, ov, lat);
    checks++; if (u !== 32'hFFFE_0000) begin failures++; $display("FAIL large_u: got %h expected fffe0000", u); end
    run_b(32'hFFFF_0000, u, ov, lat);
    checks++; if (lat !== 6) begin failures++; $display("FAIL clamp_latency: got %0d expected 6", lat); end
    checks++; if (u !== 32'h0010_0000) begin failures++; $display("FAIL clamp_u: got %h expected 00100000", u); end
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL clamp_ov: got %b expected 0", ov); end
  endtask

  task automatic test_saturation();
    logic [31:0] u; logic ov; int lat;
    run_a(32'h7FFF_FFFF, 32'h0, 32'h8000_0000, 32'h0, u, ov, lat);
    checks++; if (u !== 32'hFFFE_0000) begin failures++; $display("FAIL sat_u: got %h expected fffe0000", u); end
    checks++; if (ov !== 1'b1) begin failures++; $display("FAIL sat_ov: got %b expected 1", ov); end
    run_a(32'h0, 32'h0, 32'h0, 32'h0, u, ov, lat);
    checks++; if (u !== 32'h0) begin failures++; $display("FAIL sat_follow_u: got %h expected 00000000", u); end
    checks++; if (ov !== 1'b1) begin failures++; $display("FAIL sat_sticky_ov: got %b expected 1", ov); end
  endtask

  task automatic test_handshake();
    int n_done; int first; logic busy0; logic busy5; logic busy6;
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.theta = 32'h0001_0000; bus_a.dtheta = 32'h0; bus_a.thetan = 32'h0; bus_a.dthetan = 32'h0;
    @(negedge clk);
    bus_a.start = 1'b0;
    busy0 = bus_a.busy; busy5 = 1'b0; busy6 = 1'b1;
    n_done = 0; first = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus_a.done === 1'b1) begin n_done++; if (first < 0) first = k; end
      if (k == 5) busy5 = bus_a.busy;
      if (k == 6) busy6 = bus_a.busy;
      bus_a.start = (k == 1 || k == 3);
    end
    bus_a.start = 1'b0;
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL hs_busy_edge0: got %b expected 1", busy0); end
    checks++; if (busy5 !== 1'b1) begin failures++; $display("FAIL hs_busy_edge5: got %b expected 1", busy5); end
    checks++; if (busy6 !== 1'b0) begin failures++; $display("FAIL hs_busy_edge6: got %b expected 0", busy6); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL hs_done_count: got %0d expected 1", n_done); end
    checks++; if (first !== 6) begin failures++; $display("FAIL hs_done_edge: got %0d expected 6", first); end
  endtask

  task automatic test_back_to_back();
    int seen; int lat2; logic [31:0] u1; logic [31:0] u2;
    @(negedge clk);
    bus_a.start = 1'b1; bus_a.theta = 32'h0001_0000;
    @(negedge clk);
    bus_a.start = 1'b0;
    seen = -1; u1 = '0;
    for (int k = 1; k <= 12 && seen < 0; k++) begin
      @(negedge clk);
      if (bus_a.done === 1'b1) begin
        seen = k; u1 = bus_a.u;
        bus_a.start = 1'b1; bus_a.theta = 32'hFFFF_0000;
      end
    end
    @(negedge clk);
    bus_a.start = 1'b0; bus_a.theta = 32'h0;
    lat2 = -1; u2 = '0;
    for (int j = 1; j <= 12 && lat2 < 0; j++) begin
      @(negedge clk);
      if (bus_a.done === 1'b1) begin lat2 = j; u2 = bus_a.u; end
    end
    checks++; if (seen !== 6) begin failures++; $display("FAIL b2b_first_edge: got %0d expected 6", seen); end
    checks++; if (u1 !== 32'hFFFE_0000) begin failures++; $display("FAIL b2b_first_u: got %h expected fffe0000", u1); end
    checks++; if (lat2 !== 6) begin failures++; $display("FAIL b2b_second_latency: got %0d expected 6", lat2); end
    checks++; if (u2 !== 32'h0002_0000) begin failures++; $display("FAIL b2b_second_u: got %h expected 00020000", u2); end
  endtask

  task automatic test_abort_stop();
    int n_done; logic [31:0] u; logic ov; int lat;
    @(negedge clk);
    bus_a.start = 1'b1; bus_a.theta = 32'h0001_0000;
    @(negedge clk);
    bus_a.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus_a.stop_rst = 1'b1;
    @(negedge clk);
    bus_a.stop_rst = 1'b0;
    checks++; if (bus_a.u !== 32'h0) begin failures++; $display("FAIL stop_u: got %h expected 00000000", bus_a.u); end
    checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("FAIL stop_busy: got %b expected 0", bus_a.busy); end
    checks++; if (bus_a.ov !== 1'b0) begin failures++; $display("FAIL stop_ov: got %b expected 0", bus_a.ov); end
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus_a.done === 1'b1) n_done++;
    end
    checks++; if (n_done !== 0) begin failures++; $display("FAIL stop_no_done: got %0d expected 0", n_done); end
    run_a(32'h0001_0000, 32'h0, 32'h0, 32'h0, u, ov, lat);
    checks++; if (lat !== 6) begin failures++; $display("FAIL stop_recover_latency: got %0d expected 6", lat); end
    checks++; if (u !== 32'hFFFE_0000) begin failures++; $display("FAIL stop_recover_u: got %h expected fffe0000", u); end
  endtask

  task automatic test_abort_rst();
    int n_done; logic [31:0] u; logic ov; int lat;
    @(negedge clk);
    bus_a.start = 1'b1; bus_a.theta = 32'hFFFF_0000;
    @(negedge clk);
    bus_a.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus_a.u !== 32'h0) begin failures++; $display("FAIL rst_u: got %h expected 00000000", bus_a.u); end
    checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", bus_a.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus_a.done === 1'b1) n_done++;
    end
    checks++; if (n_done !== 0) begin failures++; $display("FAIL rst_no_done: got %0d expected 0", n_done); end
    run_a(32'hFFFF_0000, 32'h0, 32'h0, 32'h0, u, ov, lat);
    checks++; if (lat !== 6) begin failures++; $display("FAIL rst_recover_latency: got %0d expected 6", lat); end
    checks++; if (u !== 32'h0002_0000) begin failures++; $display("FAIL rst_recover_u: got %h expected 00020000", u); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus_a.stop_rst = 1'b0; bus_a.start = 1'b0;
    bus_a.theta = '0; bus_a.dtheta = '0; bus_a.thetan = '0; bus_a.dthetan = '0;
    bus_b.stop_rst = 1'b0; bus_b.start = 1'b0;
    bus_b.theta = '0; bus_b.dtheta = '0; bus_b.thetan = '0; bus_b.dthetan = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_zero_error();
    test_boundary_layer();
    test_large_error();
    test_saturation();
    test_handshake();
    test_back_to_back();
    test_abort_stop();
    test_abort_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
